alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter: SHAMT_W, $clog2(WIDTH), shift-amount field width taken from b[SHAMT_W-1:0].
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port: op  input  5  operation select; op[4]=0 base ALU op, op[4]=1 multiply/divide op.
REQ-008 SHALL have port: a, b  input  WIDTH  operands.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: result  output  WIDTH  operation result.
REQ-012 SHALL have port: flag  output  1  compare/branch condition.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, registering op, a and b; input changes after acceptance are ignored.
REQ-015 Base ops (op[4]=0) SHALL go IDLE->DONE; out_valid rises on the edge after acceptance (latency 1).
REQ-016 Base encoding op[3:0]: 0000 AND, 0001 OR, 0011 XOR, 0010 ADD, 0110 SUB (flag=a==b), 1000 SLL, 1001 SRL, 1010 SRA, 1011 SUB (flag=a!=b); all other listed ops flag=0.
REQ-017 Base compares SHALL give result=0: 1100 flag=signed a<b, 1101 signed a>=b, 1110 unsigned a<b, 1111 unsigned a>=b; unlisted codes give result=a, flag=0.
REQ-018 M ops op[2:0] (op[3] ignored): 000 MUL low WIDTH bits, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high, 100 DIV signed, 101 DIVU, 110 REM signed, 111 REMU; flag=0; division truncates toward zero; remainder takes dividend's sign.
REQ-019 M ops SHALL iterate one bit per cycle in BUSY for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 edges after acceptance.
REQ-020 Divisor zero SHALL give quotient all-ones and remainder=a, going IDLE->DONE (latency 1).
REQ-021 Signed overflow (a=most negative, b=all-ones) SHALL give DIV=a, REM=0, latency 1.
REQ-022 Iteration counter SHALL be $clog2(WIDTH)+1 bits and SHALL NOT wrap during an operation.
REQ-023 DONE SHALL hold result and flag stable until out_ready=1, then return to IDLE on that edge; in_valid in DONE SHALL be ignored (not accepted).

Reset
REQ-024 reset=1 SHALL immediately force IDLE, result=0, flag=0, out_valid=0, clear counter and operand registers, regardless of state.
REQ-025 Reset in BUSY or DONE SHALL abort the operation; no result is produced; in_ready=1 on the first edge after reset deasserts.

Configuration
REQ-026 Macro ALU_MD_MDU_EN SHALL enable the multiply/divide datapath: defined -> REQ-018..022 apply.
REQ-027 Without ALU_MD_MDU_EN, op[4]=1 SHALL complete with latency 1, result=0, flag=0; no BUSY state logic or iteration registers are synthesised.

Verification (WIDTH=32, ALU_MD_MDU_EN defined unless noted)
REQ-028 ADD a=5, b=7 -> out_valid one edge after accept, result=12, flag=0; BLT a=0xFFFFFFFF, b=1 -> result=0, flag=1.
REQ-029 MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE after 33 edges; MUL same operands -> 0x00000001; MULH a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, latency 1; REM same -> 0; DIV a=-7, b=2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-031 DIVU a=100, b=0 -> 0xFFFFFFFF; REMU -> 100; both latency 1.
REQ-032 Reset asserted at BUSY cycle 10 -> out_valid=0, result=0, no result emitted; in_ready=1 after release; out_ready held 0 for 5 cycles in DONE -> result stable, in_valid pulses not accepted.
REQ-033 Without ALU_MD_MDU_EN: MUL a=3, b=4 -> result=0, latency 1; ADD still 7.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: base ALU with optional iterative multiply/divide datapath, enabled by `define ALU_MD_MDU_EN
module alu_md #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, base_res;
  logic               flag_q, flag_d, base_flag;
  logic [SHAMT_W-1:0] sa;
  assign sa = b[SHAMT_W-1:0];
`ifdef ALU_MD_MDU_EN
  localparam logic [1:0] BUSY = 2'd1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [W2-1:0]    p_q, p_d, step, prod;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_neg, sb_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, md_res;
  logic [WIDTH:0]   sum, diff;
  // signed ops run on magnitudes; the sign is restored once the iteration finishes
  assign sa_neg   = (op[2:0] == 3'b001 || op[2:0] == 3'b010 || (op[2] && !op[0])) && a[WIDTH-1];
  assign sb_neg   = (op[2:0] == 3'b001 || (op[2] && !op[0])) && b[WIDTH-1];
  assign a_mag    = sa_neg ? -a : a;
  assign b_mag    = sb_neg ? -b : b;
  assign div_zero = op[2] && b == '0;
  assign div_ovf  = op[2] && !op[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
  // p_q holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign sum  = {1'b0, p_q[W2-1:WIDTH]} + {1'b0, m_q};
  assign diff = p_q[W2-1:WIDTH-1] - {1'b0, m_q};
  assign step = op_q[2] ? (diff[WIDTH] ? {p_q[W2-2:0], 1'b0} : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1})
                        : (p_q[0] ? {sum, p_q[WIDTH-1:1]} : {1'b0, p_q[W2-1:1]});
  assign prod   = neg_q ? -step : step;
  assign quo    = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem    = neg_q ? -step[W2-1:WIDTH] : step[W2-1:WIDTH];
  assign md_res = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[W2-1:WIDTH]);
`endif
  // single-cycle base ALU on the request operands
  always_comb begin
    base_res  = a;
    base_flag = 1'b0;
    case (op[3:0])
      4'b0000: base_res = a & b;
      4'b0001: base_res = a | b;
      4'b0011: base_res = a ^ b;
      4'b0010: base_res = a + b;
      4'b0110: begin
        base_res  = a - b;
        base_flag = a == b;
      end
      4'b1000: base_res = a << sa;
      4'b1001: base_res = a >> sa;
      4'b1010: base_res = $signed(a) >>> sa;
      4'b1011: begin
        base_res  = a - b;
        base_flag = a != b;
      end
      4'b1100: begin
        base_res  = '0;
        base_flag = $signed(a) < $signed(b);
      end
      4'b1101: begin
        base_res  = '0;
        base_flag = $signed(a) >= $signed(b);
      end
      4'b1110: begin
        base_res  = '0;
        base_flag = a < b;
      end
      4'b1111: begin
        base_res  = '0;
        base_flag = a >= b;
      end
      default: base_res = a;
    endcase
  end
  // request handshake, iteration sequencing and result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
`ifdef ALU_MD_MDU_EN
    op_d  = op_q;
    neg_d = neg_q;
    m_d   = m_q;
    p_d   = p_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = DONE;
        result_d = op[4] ? '0 : base_res;
        flag_d   = op[4] ? 1'b0 : base_flag;
`ifdef ALU_MD_MDU_EN
        if (op[4] && div_zero) result_d = op[1] ? a : '1;
        else if (op[4] && div_ovf) result_d = op[1] ? '0 : a;
        else if (op[4]) begin
          state_d = BUSY;
          op_d    = op[2:0];
          neg_d   = sa_neg ^ (sb_neg && !op[1]);
          m_d     = op[2] ? b_mag : a_mag;
          p_d     = {{WIDTH{1'b0}}, op[2] ? a_mag : b_mag};
          cnt_d   = '0;
        end
`endif
      end
`ifdef ALU_MD_MDU_EN
      BUSY: begin
        p_d   = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = md_res;
          flag_d   = 1'b0;
          cnt_d    = '0;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifdef ALU_MD_MDU_EN
      op_q  <= '0;
      neg_q <= 1'b0;
      m_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
`ifdef ALU_MD_MDU_EN
      op_q  <= op_d;
      neg_q <= neg_d;
      m_q   <= m_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign flag      = flag_q;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md; multiply/divide vectors run when ALU_MD_MDU_EN is defined
module tb_alu_md;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, flag;
  logic [31:0] result;
  always #5 clk = ~clk;
  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag(flag)
  );
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        flag;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int   cyc = 0, n_vec = 0, n_miss = 0;
  logic ov_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_output: got result=%h flag=%b, want no output", result, flag);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || flag !== e.flag || cyc - e.t0 != e.lat) begin
          n_miss++;
          $display("FAIL op=%b a=%h b=%h: got result=%h flag=%b lat=%0d, want result=%h flag=%b lat=%0d",
                   e.op, e.a, e.b, result, flag, cyc - e.t0, e.res, e.flag, e.lat);
        end
      end
    end
    ov_prev <= out_valid;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic f, input int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout op=%b: got in_ready=0, want 1", o);
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    sb.push_back('{o, x, y, r, f, lat, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL result_timeout op=%b: got no out_valid, want result %h", o, r);
      sb.delete();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_ready_valid_flag", {29'd0, in_ready, out_valid, flag}, 32'd4);
    reset = 1'b0;
    issue(5'b00010, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    issue(5'b01100, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1);
    issue(5'b00000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1);
    issue(5'b00001, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1);
    issue(5'b00011, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 1);
    issue(5'b00110, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    issue(5'b01011, 32'd10, 32'd3, 32'd7, 1'b1, 1);
    issue(5'b01000, 32'd1, 32'd36, 32'h10, 1'b0, 1);
    issue(5'b01001, 32'h80000000, 32'd31, 32'd1, 1'b0, 1);
    issue(5'b01010, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
    issue(5'b01101, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
    issue(5'b01110, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
    issue(5'b01111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
    issue(5'b00100, 32'h1234, 32'd5, 32'h1234, 1'b0, 1);
`ifdef ALU_MD_MDU_EN
    issue(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    issue(5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
    issue(5'b10001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
    issue(5'b11010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
    issue(5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    issue(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
    issue(5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
    issue(5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
    issue(5'b10100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    issue(5'b10110, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 33);
    issue(5'b10101, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
    issue(5'b10111, 32'd100, 32'd0, 32'd100, 1'b0, 1);
    issue(5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    issue(5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
`else
    issue(5'b10000, 32'd3, 32'd4, 32'd0, 1'b0, 1);
    issue(5'b10101, 32'd100, 32'd0, 32'd0, 1'b0, 1);
`endif
    out_ready = 1'b0;
    issue(5'b00010, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'd7);
      check("hold_valid_ready_flag", {29'd0, out_valid, in_ready, flag}, 32'd4);
      in_valid = 1'b1;
      op = 5'b00010;
      a = 32'd100 + i;
      b = 32'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("release_result", result, 32'd7);
    out_ready = 1'b0;
    issue(5'b00010, 32'd20, 32'd22, 32'd42, 1'b0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_done_result", result, 32'd0);
    check("reset_done_ctl", {29'd0, in_ready, out_valid, flag}, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_MD_MDU_EN
    @(negedge clk);
    op = 5'b10011;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_ready_valid", {30'd0, in_ready, out_valid}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_busy_result", result, 32'd0);
    check("reset_busy_ctl", {29'd0, in_ready, out_valid, flag}, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
`endif
    issue(5'b00010, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
